// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
    ALU_OR  = 3'b011, ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10} srca_t;
  typedef enum logic [1:0] {SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} srcb_t;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10} res_t;
  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_t;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational instruction-field decode: ALU operation and illegal-instruction flag.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_ctrl_o,
  output logic       illegal_o
);

  // Map opcode/funct3/funct7[30] to an ALU op; unsupported encodings flag illegal.
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = funct7b5_i ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl_o = ALU_AND;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b010:  alu_ctrl_o = ALU_SLT;
          default: illegal_o  = 1'b1;
        endcase
      end
      OP_ITYPE: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = ALU_ADD;
          3'b111:  alu_ctrl_o = ALU_AND;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b010:  alu_ctrl_o = ALU_SLT;
          default: illegal_o  = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        alu_ctrl_o = ALU_SUB;
        illegal_o  = (funct3_i[2:1] != 2'b00);
      end
      OP_LOAD, OP_STORE, OP_JAL: alu_ctrl_o = ALU_ADD;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I datapath.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 EQ,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 Data_WE,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ALUctrl,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           ResultSrc,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 halted_q, halted_d;
  logic [2:0]           dec_alu;
  logic                 dec_illegal;
  logic                 unused_instr_bits;

  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .opcode_i   (instr[6:0]),
    .funct3_i   (instr[14:12]),
    .funct7b5_i (instr[30]),
    .alu_ctrl_o (dec_alu),
    .illegal_o  (dec_illegal)
  );

  // State, retired counter and sticky halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    Data_WE   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ALUctrl   = ALU_ADD;
    ImmSrc    = IMM_I;
    ResultSrc = RES_ALUOUT;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
        if (dec_illegal) state_d = HALT;
        else begin
          case (instr[6:0])
            OP_LOAD, OP_STORE: state_d = MEMADR;
            OP_RTYPE:          state_d = EXECR;
            OP_ITYPE:          state_d = EXECI;
            OP_BRANCH:         state_d = BRANCH;
            OP_JAL:            state_d = JAL;
            default:           state_d = HALT;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        if (instr[6:0] == OP_STORE) begin
          ImmSrc  = IMM_S;
          state_d = MEMWRITE;
        end else begin
          state_d = MEMREAD;
        end
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        mem_req = 1'b1;
        Data_WE = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUctrl = dec_alu;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUctrl = dec_alu;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA = SRCA_RD1;
        ALUctrl = ALU_SUB;
        PCWrite = EQ ^ instr[12];
        state_d = FETCH;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = ALUWB;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

    // Reset is asynchronous, so outputs are forced low combinationally while it is held.
    if (rst) begin
      mem_req   = 1'b0;
      Data_WE   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RD2;
      ALUctrl   = ALU_ADD;
      ImmSrc    = IMM_I;
      ResultSrc = RES_ALUOUT;
    end

    count_d  = count_q;
    if (state_d == FETCH && state_q != FETCH) count_d = count_q + CNT_WIDTH'(1);
    halted_d = halted_q | (state_d == HALT);
  end

  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vector and counter checks.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        EQ = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, Data_WE, AdrSrc, IRWrite, PCWrite, RegWrite, halted;
  logic [1:0]  ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
  logic [2:0]  ALUctrl;
  logic [31:0] instr_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] cur = '0;
  logic [17:0] obs;

  multicycle_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
    .mem_req(mem_req), .Data_WE(Data_WE), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, Data_WE, AdrSrc, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, ResultSrc, halted};

  function automatic logic [17:0] ctl(input logic mr, input logic we, input logic adr,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu, input logic [1:0] imm,
                                      input logic [1:0] rs, input logic h);
    return {mr, we, adr, irw, pcw, rw, sa, sb, alu, imm, rs, h};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns later.
  task automatic cyc(input logic r, input logic rdy, input logic eq,
                     input logic [17:0] exp, input string tag);
    @(negedge clk);
    rst = r; mem_ready = rdy; EQ = eq; instr = cur;
    #1;
    check(tag, {14'd0, obs}, {14'd0, exp});
  endtask

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_SUB  = 32'h40208033;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ORI  = 32'h0060E093;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] F_RDY, F_WAIT, DEC, EXI_ADD, EXI_OR, EXR_SUB, WB, MA_SW;
    logic [17:0] MR, MEMWB, MW, BR_T, BR_N, JALV, HLT;
    F_RDY   = ctl(1,0,0,1,1,0,2'b00,2'b10,3'b000,2'b00,2'b10,0);
    F_WAIT  = ctl(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b00,2'b10,0);
    DEC     = ctl(0,0,0,0,0,0,2'b01,2'b01,3'b000,2'b10,2'b00,0);
    EXI_ADD = ctl(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,2'b00,0);
    EXI_OR  = ctl(0,0,0,0,0,0,2'b10,2'b01,3'b011,2'b00,2'b00,0);
    EXR_SUB = ctl(0,0,0,0,0,0,2'b10,2'b00,3'b001,2'b00,2'b00,0);
    WB      = ctl(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,2'b00,0);
    MA_SW   = ctl(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b01,2'b00,0);
    MR      = ctl(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0);
    MEMWB   = ctl(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,2'b01,0);
    MW      = ctl(1,1,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0);
    BR_T    = ctl(0,0,0,0,1,0,2'b10,2'b00,3'b001,2'b00,2'b00,0);
    BR_N    = ctl(0,0,0,0,0,0,2'b10,2'b00,3'b001,2'b00,2'b00,0);
    JALV    = ctl(0,0,0,0,1,0,2'b01,2'b10,3'b000,2'b00,2'b00,0);
    HLT     = ctl(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,1);

    // Reset held 3 cycles with ready asserted: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, '0, "rst_outputs");
      check("rst_count", instr_count, 0);
    end
    cyc(0, 0, 0, F_WAIT, "rel_fetch");
    check("rel_count", instr_count, 0);

    // addi, zero-wait memory.
    cur = I_ADDI;
    cyc(0, 1, 0, F_RDY,   "addi_fetch");
    cyc(0, 1, 0, DEC,     "addi_decode");
    cyc(0, 1, 0, EXI_ADD, "addi_execi");
    cyc(0, 1, 0, WB,      "addi_aluwb");

    // lw with two wait cycles in FETCH and one in MEMREAD (8 cycles).
    cur = I_LW;
    cyc(0, 0, 0, F_WAIT,  "lw_fetch_w1");
    check("cnt_after_addi", instr_count, 1);
    cyc(0, 0, 0, F_WAIT,  "lw_fetch_w2");
    cyc(0, 1, 0, F_RDY,   "lw_fetch");
    cyc(0, 1, 0, DEC,     "lw_decode");
    cyc(0, 1, 0, EXI_ADD, "lw_memadr");
    cyc(0, 0, 0, MR,      "lw_memread_w");
    cyc(0, 1, 0, MR,      "lw_memread");
    cyc(0, 1, 0, MEMWB,   "lw_memwb");

    cur = I_BEQ;
    cyc(0, 1, 0, F_RDY, "beq_fetch");
    check("cnt_after_lw", instr_count, 2);
    cyc(0, 1, 0, DEC,   "beq_decode");
    cyc(0, 1, 1, BR_T,  "beq_taken");

    cur = I_BNE;
    cyc(0, 1, 0, F_RDY, "bne_fetch");
    check("cnt_after_beq", instr_count, 3);
    cyc(0, 1, 0, DEC,   "bne_decode");
    cyc(0, 1, 1, BR_N,  "bne_not_taken");

    cur = I_SW;
    cyc(0, 1, 0, F_RDY, "sw_fetch");
    check("cnt_after_bne", instr_count, 4);
    cyc(0, 1, 0, DEC,   "sw_decode");
    cyc(0, 1, 0, MA_SW, "sw_memadr");
    cyc(0, 1, 0, MW,    "sw_memwrite");

    cur = I_SUB;
    cyc(0, 1, 0, F_RDY,   "sub_fetch");
    check("cnt_after_sw", instr_count, 5);
    cyc(0, 1, 0, DEC,     "sub_decode");
    cyc(0, 1, 0, EXR_SUB, "sub_execr");
    cyc(0, 1, 0, WB,      "sub_aluwb");

    cur = I_JAL;
    cyc(0, 1, 0, F_RDY, "jal_fetch");
    check("cnt_after_sub", instr_count, 6);
    cyc(0, 1, 0, DEC,   "jal_decode");
    cyc(0, 1, 0, JALV,  "jal_jal");
    cyc(0, 1, 0, WB,    "jal_aluwb");

    cur = I_ORI;
    cyc(0, 1, 0, F_RDY,  "ori_fetch");
    check("cnt_after_jal", instr_count, 7);
    cyc(0, 1, 0, DEC,    "ori_decode");
    cyc(0, 1, 0, EXI_OR, "ori_execi");
    cyc(0, 1, 0, WB,     "ori_aluwb");

    // Illegal opcode: HALT for 20 cycles regardless of ready.
    cur = I_ILL;
    cyc(0, 1, 0, F_RDY, "ill_fetch");
    check("cnt_after_ori", instr_count, 8);
    cyc(0, 1, 0, DEC,   "ill_decode");
    for (int i = 0; i < 20; i++) begin
      cyc(0, logic'(i % 2), 0, HLT, "halt_state");
      check("halt_count", instr_count, 8);
    end

    // Reset exits HALT.
    cyc(1, 0, 0, '0, "rst2_outputs");
    check("rst2_count", instr_count, 0);
    cur = I_ADDI;
    cyc(0, 1, 0, F_RDY,   "addi2_fetch");
    cyc(0, 1, 0, DEC,     "addi2_decode");
    cyc(0, 1, 0, EXI_ADD, "addi2_execi");
    cyc(0, 1, 0, WB,      "addi2_aluwb");

    // Reset in the middle of a stalled store.
    cur = I_SW;
    cyc(0, 1, 0, F_RDY, "sw2_fetch");
    check("cnt_after_addi2", instr_count, 1);
    cyc(0, 1, 0, DEC,   "sw2_decode");
    cyc(0, 1, 0, MA_SW, "sw2_memadr");
    cyc(0, 0, 0, MW,    "sw2_memwrite_wait");
    cyc(1, 0, 0, '0,    "rst_mid_outputs");
    check("rst_mid_count", instr_count, 0);
    cyc(0, 0, 0, F_WAIT, "restart_fetch");
    check("restart_count", instr_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
